// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the EX stage: fixed-latency mult/multu/div/divu
// plus single-cycle mthi/mtlo, with busy/done handshakes to the hazard logic.
//
// state | meaning
// IDLE  | accepting ops; mthi/mtlo write HI/LO directly
// MUL   | counting MULT_CYCLES, then {hi,lo} <= product
// DIV   | counting DIV_CYCLES, then lo <= quotient, hi <= remainder
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) > 5) ? $clog2(MAXC + 1) : 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic          sgn_q, sgn_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q;
  logic          done_q, done_d;

  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b;
  logic [31:0] uquot, urem, quot, rem;

  always_comb begin
    ext_a = sgn_q ? {{32{opa_q[31]}}, opa_q} : {32'b0, opa_q};
    ext_b = sgn_q ? {{32{opb_q[31]}}, opb_q} : {32'b0, opb_q};
    prod  = ext_a * ext_b;
  end

  // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    neg_a = sgn_q & opa_q[31];
    neg_b = sgn_q & opb_q[31];
    mag_a = neg_a ? (~opa_q + 32'd1) : opa_q;
    mag_b = neg_b ? (~opb_q + 32'd1) : opb_q;
    div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uquot = mag_a / div_b;
    urem  = mag_a % div_b;
    quot  = (neg_a ^ neg_b) ? (~uquot + 32'd1) : uquot;
    rem   = neg_a ? (~urem + 32'd1) : urem;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          unique case (op_i)
            3'b000, 3'b001: begin
              opa_d   = a_i;
              opb_d   = b_i;
              sgn_d   = ~op_i[0];
              cnt_d   = CW'(1);
              state_d = S_MUL;
            end
            3'b010, 3'b011: begin
              opa_d   = a_i;
              opb_d   = b_i;
              sgn_d   = ~op_i[0];
              cnt_d   = CW'(1);
              state_d = S_DIV;
            end
            3'b100:  hi_d = a_i;
            3'b101:  lo_d = a_i;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == CW'(MULT_CYCLES)) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == CW'(DIV_CYCLES)) begin
          // Divide by zero still completes and pulses done but keeps HI/LO.
          if (opb_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO per mult/div,
// a negedge monitor pops and compares whenever done is seen.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi, m_lo;
  logic        prev_done;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op),
    .a_i(a), .b_i(b), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the ISA definitions.
  task automatic accept_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    exp_t            e;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      3'd0: begin
        sp = longint'(sx) * longint'(sy);
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      3'd1: begin
        up = longint'({32'b0, x}) * longint'({32'b0, y});
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      3'd2: begin
        if (y == 0) begin
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'h0;
        end else begin
          m_lo = sx / sy; m_hi = sx % sy;
        end
      end
      3'd3: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
    if (o <= 3'd3) begin
      e.hi = m_hi; e.lo = m_lo;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (prev_done) check("done_width", 64'(prev_done & done), 64'd0);
      if (sb_q.size() == 0) begin
        check("done_unexpected", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_hi", 64'(hi), 64'(e.hi));
        check("sb_lo", 64'(lo), 64'(e.lo));
      end
    end
    prev_done = done;
  end

  // Entered at the negedge just after the accepting edge; returns at the
  // negedge where busy has dropped.
  task automatic busy_phase(input int n, input bit inj, input bit chain,
                            input logic [31:0] ca, input logic [31:0] cb);
    int cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      if (inj && cnt == 3) begin
        start = 1'b1; op = 3'b101; a = 32'h0000_DEAD; b = 32'h0000_BEEF;
      end else if (chain && cnt == n) begin
        start = 1'b1; op = 3'b010; a = ca; b = cb;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
      @(negedge clk);
    end
    check("busy_cycles", 64'(cnt), 64'(n));
    check("done_at_fall", 64'(done), 64'd1);
    if (chain) begin
      check("chain_not_early", 64'(busy), 64'd0);
      @(negedge clk);
      start = 1'b0;
      accept_model(3'b010, ca, cb);
      busy_phase(DC, 1'b0, 1'b0, 32'd0, 32'd0);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit inj = 1'b0, input bit chain = 1'b0,
                       input logic [31:0] ca = 32'd0, input logic [31:0] cb = 32'd0);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    accept_model(o, x, y);
    if (o <= 3'd3) begin
      busy_phase((o <= 3'd1) ? MC : DC, inj, chain, ca, cb);
    end else begin
      check("single_busy", 64'(busy), 64'd0);
      check("single_hi", 64'(hi), 64'(m_hi));
      check("single_lo", 64'(lo), 64'(m_lo));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    m_hi = '0; m_lo = '0; prev_done = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h5555_AAAA;
    @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    start = 1'b0; reset = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(3'd3, 32'd7, 32'd0);
    check("divu_zero", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});
    do_op(3'd4, 32'h1234_5678, 32'd0);
    check("mthi", 64'(hi), 64'h1234_5678);
    do_op(3'd6, 32'hCAFE_F00D, 32'd1);

    do_op(3'd0, 32'd1000, 32'hFFFF_FFF0, 1'b1);
    check("mult_inj", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_C180});
    do_op(3'd1, 32'd12, 32'd12, 1'b0, 1'b1, 32'd100, 32'hFFFF_FFFD);

    // Reset mid-divu aborts with no result and no done.
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    do_op(3'd0, 32'd6, 32'd7);
    check("post_rst_mult", {hi, lo}, 64'd42);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
